sys_ctrl: RTL and testbench

- Command sequencer between the UART RX deserializer, the register file, the ALU and the UART TX async FIFO.
- Consumes byte frames (rx_p_data / rx_d_vld) and decodes 4 command types.
- Drives register-file write/read, ALU operand load, clock-gate enable and function select.
- Pushes response bytes into the TX FIFO.

---
 rtl/sys_ctrl_if.sv | 47 ++++
 rtl/sys_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_if.sv
// rtl/sys_ctrl_if.sv - bus bundle between sys_ctrl and the RX, register file, ALU and TX FIFO
//
// Purpose: groups every non-clock/reset signal of sys_ctrl.
// Modports:
//   master - the sequencer (sys_ctrl): consumes RX bytes and read/ALU results,
//            drives register-file, ALU and TX FIFO controls.
//   slave  - the surrounding blocks: the mirror image of master.
// Signal summary:
//   rx_p_data/rx_d_vld         received byte + 1-cycle strobe
//   rd_data/rd_data_valid      register file read data + strobe
//   alu_out/alu_out_valid      ALU result (2*DATA_WIDTH) + strobe
//   fifo_full                  TX FIFO full
//   addr/wr_en/wr_data/rd_en   register file access
//   alu_en/alu_fun/clk_g_en    ALU enable, function select, clock-gate enable
//   tx_p_data/tx_d_vld         byte to TX FIFO + write strobe
interface sys_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    rx_p_data;
  logic                     rx_d_vld;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_data_valid;
  logic [2*DATA_WIDTH-1:0]  alu_out;
  logic                     alu_out_valid;
  logic                     fifo_full;
  logic [ADDR_WIDTH-1:0]    addr;
  logic                     wr_en;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     rd_en;
  logic                     alu_en;
  logic [ALU_FUN_WIDTH-1:0] alu_fun;
  logic                     clk_g_en;
  logic [DATA_WIDTH-1:0]    tx_p_data;
  logic                     tx_d_vld;

  modport master (
    input  rx_p_data, rx_d_vld, rd_data, rd_data_valid, alu_out, alu_out_valid, fifo_full,
    output addr, wr_en, wr_data, rd_en, alu_en, alu_fun, clk_g_en, tx_p_data, tx_d_vld
  );

  modport slave (
    output rx_p_data, rx_d_vld, rd_data, rd_data_valid, alu_out, alu_out_valid, fifo_full,
    input  addr, wr_en, wr_data, rd_en, alu_en, alu_fun, clk_g_en, tx_p_data, tx_d_vld
  );
endinterface

// File: rtl/sys_ctrl.sv
// rtl/sys_ctrl.sv - command sequencer between UART RX, register file, ALU and UART TX FIFO
//
// Purpose: decodes byte frames from the RX deserializer into register
// write/read and ALU commands, and pushes response bytes to the TX FIFO.
//   0xAA ADDR DATA      register write
//   0xBB ADDR           register read, responds with one byte
//   0xCC OPA OPB FUN    load operands into regs 0/1, run ALU, responds LSB then MSB
//   0xDD FUN            run ALU on current operands, responds LSB then MSB
// Ports:
//   clk  - system clock
//   rst  - synchronous active-low reset
//   bus  - sys_ctrl_if master modport (see rtl/sys_ctrl_if.sv)
// All outputs are registered; strobes (wr_en, rd_en, tx_d_vld) are single-cycle,
// addr/wr_data/alu_fun/tx_p_data hold their last value.
module sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  sys_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, SEND_RD,
    OPA, OPB, ALU_FUN, ALU_WAIT, SEND_LSB, SEND_MSB
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   rd_buf;
  logic [2*DATA_WIDTH-1:0] alu_buf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rd_buf        <= '0;
      alu_buf       <= '0;
      bus.addr      <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_data   <= '0;
      bus.rd_en     <= 1'b0;
      bus.alu_en    <= 1'b0;
      bus.alu_fun   <= '0;
      bus.clk_g_en  <= 1'b0;
      bus.tx_p_data <= '0;
      bus.tx_d_vld  <= 1'b0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      bus.wr_en    <= 1'b0;
      bus.rd_en    <= 1'b0;
      bus.tx_d_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.rx_d_vld) begin
            case (bus.rx_p_data)
              CMD_WR:     state <= WR_ADDR;
              CMD_RD:     state <= RD_ADDR;
              CMD_ALU_OP: state <= OPA;
              CMD_ALU:    state <= ALU_FUN;
              default:    state <= IDLE;
            endcase
          end
        end

        WR_ADDR: begin
          if (bus.rx_d_vld) begin
            bus.addr <= bus.rx_p_data[ADDR_WIDTH-1:0];
            state    <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (bus.rx_d_vld) begin
            bus.wr_data <= bus.rx_p_data;
            bus.wr_en   <= 1'b1;
            state       <= IDLE;
          end
        end

        RD_ADDR: begin
          if (bus.rx_d_vld) begin
            bus.addr  <= bus.rx_p_data[ADDR_WIDTH-1:0];
            bus.rd_en <= 1'b1;
            state     <= RD_WAIT;
          end
        end

        // RX bytes arriving while waiting or sending are dropped on purpose.
        RD_WAIT: begin
          if (bus.rd_data_valid) begin
            rd_buf <= bus.rd_data;
            state  <= SEND_RD;
          end
        end

        SEND_RD: begin
          if (!bus.fifo_full) begin
            bus.tx_p_data <= rd_buf;
            bus.tx_d_vld  <= 1'b1;
            state         <= IDLE;
          end
        end

        // Operands live in register-file locations 0 and 1.
        OPA: begin
          if (bus.rx_d_vld) begin
            bus.addr    <= '0;
            bus.wr_data <= bus.rx_p_data;
            bus.wr_en   <= 1'b1;
            state       <= OPB;
          end
        end

        OPB: begin
          if (bus.rx_d_vld) begin
            bus.addr    <= ADDR_WIDTH'(1);
            bus.wr_data <= bus.rx_p_data;
            bus.wr_en   <= 1'b1;
            state       <= ALU_FUN;
          end
        end

        ALU_FUN: begin
          if (bus.rx_d_vld) begin
            bus.alu_fun  <= bus.rx_p_data[ALU_FUN_WIDTH-1:0];
            bus.alu_en   <= 1'b1;
            bus.clk_g_en <= 1'b1;
            state        <= ALU_WAIT;
          end
        end

        // ALU clock stays ungated until the result comes back.
        ALU_WAIT: begin
          if (bus.alu_out_valid) begin
            alu_buf      <= bus.alu_out;
            bus.alu_en   <= 1'b0;
            bus.clk_g_en <= 1'b0;
            state        <= SEND_LSB;
          end
        end

        SEND_LSB: begin
          if (!bus.fifo_full) begin
            bus.tx_p_data <= alu_buf[DATA_WIDTH-1:0];
            bus.tx_d_vld  <= 1'b1;
            state         <= SEND_MSB;
          end
        end

        SEND_MSB: begin
          if (!bus.fifo_full) begin
            bus.tx_p_data <= alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
            bus.tx_d_vld  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb/tb_sys_ctrl.sv - self-checking bench for sys_ctrl
module tb_sys_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_if bus ();

  sys_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Register file as seen through the DUT's write port; feeds reads and the ALU.
  logic [7:0] rf [16];
  // Reference contents derived only from the commands issued.
  logic [7:0] model_mem [16];

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         tx_cnt = 0;
  int         full_push_err = 0;
  logic       full_at_edge = 1'b0;
  logic [3:0] last_rd_addr = '0;
  logic [7:0] tx_q [$];

  always @(posedge clk) full_at_edge = bus.fifo_full;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      rf[bus.addr] = bus.wr_data;
    end
    if (bus.rd_en === 1'b1) begin
      rd_cnt++;
      last_rd_addr = bus.addr;
    end
    if (bus.tx_d_vld === 1'b1) begin
      tx_cnt++;
      tx_q.push_back(bus.tx_p_data);
      if (full_at_edge) full_push_err++;
    end
  end

  function automatic logic [28:0] outs();
    return {bus.addr, bus.wr_en, bus.wr_data, bus.rd_en, bus.alu_en, bus.alu_fun,
            bus.clk_g_en, bus.tx_p_data, bus.tx_d_vld};
  endfunction

  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {a ^ b, f, 4'h0};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    tick();
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic wait_tx(input int n, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      bus.fifo_full = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      ok = (tx_cnt >= n);
    end
    bus.fifo_full = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int wr0 = wr_cnt;
    int tx0 = tx_cnt;
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    vectors++;
    if ({bus.wr_en, bus.addr, bus.wr_data} !== {1'b1, a[3:0], d}) begin
      miscompares++;
      $display("FAIL wr_pulse: got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
               bus.wr_en, bus.addr, bus.wr_data, a[3:0], d);
    end
    model_mem[a[3:0]] = d;
    tick();
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.addr !== a[3:0] || wr_cnt != wr0 + 1 || tx_cnt != tx0) begin
      miscompares++;
      $display("FAIL wr_once: got en=%b addr=%h writes=%0d tx=%0d want en=0 addr=%h writes=%0d tx=%0d",
               bus.wr_en, bus.addr, wr_cnt - wr0, tx_cnt - tx0, a[3:0], 1, 0);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int delay, input int full_cyc,
                         input logic [7:0] junk, input bit send_junk);
    int         rd0 = rd_cnt;
    int         tx0 = tx_cnt;
    bit         ok;
    logic [7:0] exp = model_mem[a[3:0]];
    send_byte(8'hBB);
    send_byte(a);
    vectors++;
    if (bus.rd_en !== 1'b1 || bus.addr !== a[3:0]) begin
      miscompares++;
      $display("FAIL rd_pulse: got en=%b addr=%h want en=1 addr=%h", bus.rd_en, bus.addr, a[3:0]);
    end
    tick();
    vectors++;
    if (bus.rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_once: got rd_en=%b want 0", bus.rd_en);
    end
    if (send_junk) send_byte(junk);
    repeat (delay) tick();
    bus.fifo_full     = (full_cyc > 0);
    bus.rd_data       = rf[last_rd_addr];
    bus.rd_data_valid = 1'b1;
    tick();
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = 8'($urandom);
    repeat (full_cyc) tick();
    vectors++;
    if (tx_cnt != tx0) begin
      miscompares++;
      $display("FAIL rd_hold_full: got %0d pushes want 0", tx_cnt - tx0);
    end
    wait_tx(tx0 + 1, 1'b0, ok);
    vectors++;
    if (!ok || tx_q[tx0] !== exp) begin
      miscompares++;
      $display("FAIL rd_resp: got ok=%b byte=%h want ok=1 byte=%h", ok, ok ? tx_q[tx0] : 8'h00, exp);
    end
    repeat (4) tick();
    vectors++;
    if (tx_cnt != tx0 + 1 || rd_cnt != rd0 + 1) begin
      miscompares++;
      $display("FAIL rd_count: got tx=%0d rd=%0d want tx=1 rd=1", tx_cnt - tx0, rd_cnt - rd0);
    end
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [7:0] fun, input int delay, input int full_cyc,
                        input bit rnd_full, input bit use_fixed, input logic [15:0] fixed);
    int          tx0 = tx_cnt;
    bit          ok;
    logic [15:0] exp;
    if (with_ops) begin
      send_byte(8'hCC);
      send_byte(opa);
      vectors++;
      if ({bus.wr_en, bus.addr, bus.wr_data} !== {1'b1, 4'd0, opa}) begin
        miscompares++;
        $display("FAIL opa_write: got en=%b addr=%h data=%h want en=1 addr=0 data=%h",
                 bus.wr_en, bus.addr, bus.wr_data, opa);
      end
      model_mem[0] = opa;
      send_byte(opb);
      vectors++;
      if ({bus.wr_en, bus.addr, bus.wr_data} !== {1'b1, 4'd1, opb}) begin
        miscompares++;
        $display("FAIL opb_write: got en=%b addr=%h data=%h want en=1 addr=1 data=%h",
                 bus.wr_en, bus.addr, bus.wr_data, opb);
      end
      model_mem[1] = opb;
    end else begin
      send_byte(8'hDD);
    end
    send_byte(fun);
    vectors++;
    if ({bus.alu_en, bus.clk_g_en, bus.alu_fun} !== {2'b11, fun[3:0]}) begin
      miscompares++;
      $display("FAIL alu_start: got en=%b gate=%b fun=%h want en=1 gate=1 fun=%h",
               bus.alu_en, bus.clk_g_en, bus.alu_fun, fun[3:0]);
    end
    repeat (delay) tick();
    vectors++;
    if (bus.alu_en !== 1'b1 || bus.clk_g_en !== 1'b1 || tx_cnt != tx0) begin
      miscompares++;
      $display("FAIL alu_hold: got en=%b gate=%b want en=1 gate=1", bus.alu_en, bus.clk_g_en);
    end
    exp = use_fixed ? fixed : alu_model(fun[3:0], model_mem[0], model_mem[1]);
    bus.alu_out       = use_fixed ? fixed : alu_model(bus.alu_fun, rf[0], rf[1]);
    bus.alu_out_valid = 1'b1;
    bus.fifo_full     = (full_cyc > 0);
    tick();
    bus.alu_out_valid = 1'b0;
    bus.alu_out       = 16'($urandom);
    vectors++;
    if (bus.alu_en !== 1'b0 || bus.clk_g_en !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_stop: got en=%b gate=%b want en=0 gate=0", bus.alu_en, bus.clk_g_en);
    end
    repeat (full_cyc) tick();
    vectors++;
    if (tx_cnt != tx0) begin
      miscompares++;
      $display("FAIL alu_hold_full: got %0d pushes want 0", tx_cnt - tx0);
    end
    wait_tx(tx0 + 2, rnd_full, ok);
    vectors++;
    if (!ok || tx_q[tx0] !== exp[7:0] || tx_q[tx0+1] !== exp[15:8]) begin
      miscompares++;
      $display("FAIL alu_resp: got ok=%b bytes=%h,%h want ok=1 bytes=%h,%h", ok,
               ok ? tx_q[tx0] : 8'h00, ok ? tx_q[tx0+1] : 8'h00, exp[7:0], exp[15:8]);
    end
    repeat (3) tick();
    vectors++;
    if (tx_cnt != tx0 + 2 || bus.clk_g_en !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_count: got tx=%0d gate=%b want tx=2 gate=0", tx_cnt - tx0, bus.clk_g_en);
    end
  endtask

  task automatic test_reset();
    int wr0;
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst = 1'b1;
    tick();
    wr0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    rst = 1'b0;
    tick();
    vectors++;
    if (outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want 0", outs());
    end
    rst = 1'b1;
    send_byte(8'h33);
    repeat (3) tick();
    vectors++;
    if (wr_cnt != wr0 || outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_discard: got writes=%0d outs=%h want writes=0 outs=0", wr_cnt - wr0, outs());
    end
    do_write(8'h0F, 8'h11);
  endtask

  task automatic test_write();
    do_write(8'h03, 8'h5A);
    do_write(8'hF6, 8'h81);   // upper address bits truncated
  endtask

  task automatic test_read();
    do_write(8'h07, 8'hC3);
    do_read(8'h07, 2, 0, 8'h00, 1'b0);
  endtask

  task automatic test_alu_ops();
    do_alu(1'b1, 8'h10, 8'h20, 8'h00, 3, 0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_alu_backpressure();
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 2, 5, 1'b0, 1'b1, 16'hABCD);
  endtask

  task automatic test_illegal();
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    send_byte(8'h7E);
    repeat (2) tick();
    vectors++;
    if (wr_cnt != wr0 || rd_cnt != rd0 || bus.alu_en !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_op: got writes=%0d reads=%0d alu_en=%b want 0,0,0",
               wr_cnt - wr0, rd_cnt - rd0, bus.alu_en);
    end
    do_read(8'h01, 3, 0, 8'h99, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] junk;
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'($urandom));
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        while (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'($urandom);
        send_byte(junk);
      end
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                   8'($urandom), 1'($urandom_range(0, 1)));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                  $urandom_range(0, 3), 1'b1, 1'b0, 16'h0000);
        default: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), $urandom_range(0, 4),
                        $urandom_range(0, 3), 1'b1, 1'b0, 16'h0000);
      endcase
    end
    vectors++;
    if (full_push_err != 0) begin
      miscompares++;
      $display("FAIL push_while_full: got %0d pushes want 0", full_push_err);
    end
  endtask

  initial begin
    bus.rx_p_data     = '0;
    bus.rx_d_vld      = 1'b0;
    bus.rd_data       = '0;
    bus.rd_data_valid = 1'b0;
    bus.alu_out       = '0;
    bus.alu_out_valid = 1'b0;
    bus.fifo_full     = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_alu_backpressure();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
